// File: rtl/alu_writeback_stage_pkg.sv
// Shared types for the ALU writeback stage: flag bit positions, the stored
// writeback record and the skid-buffer occupancy encoding.
package alu_writeback_stage_pkg;

    localparam int SIZE_DATA           = 32;
    localparam int SIZE_PHYSICAL_LOG   = 7;
    localparam int SIZE_ACTIVELIST_LOG = 5;
    localparam int EXECUTION_FLAGS     = 6;

    localparam int FLAG_EXEC = 2;
    localparam int FLAG_EXCP = 1;
    localparam int FLAG_MISP = 0;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_state_e;

    // Field order here is the bit order of the flattened entry in the stage.
    typedef struct packed {
        logic [SIZE_DATA-1:0]           result;
        logic [EXECUTION_FLAGS-1:0]     flags;
        logic                           has_dest;
        logic [SIZE_PHYSICAL_LOG-1:0]   phy_dest;
        logic [SIZE_ACTIVELIST_LOG-1:0] al_id;
    } wb_entry_t;

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Bundle of the ALU-side input, the writeback/completion outputs and the bypass
// outputs of the writeback stage; slave is the stage's view, master the environment's.
interface alu_writeback_stage_if
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_W = SIZE_DATA,
    parameter int PHY_W  = SIZE_PHYSICAL_LOG,
    parameter int AL_W   = SIZE_ACTIVELIST_LOG,
    parameter int FLG_W  = EXECUTION_FLAGS
) ();

    logic              valid_i;
    logic [DATA_W-1:0] result_i;
    logic [FLG_W-1:0]  flags_i;
    logic              has_dest_i;
    logic [PHY_W-1:0]  phy_dest_i;
    logic [AL_W-1:0]   al_id_i;
    logic              ready_o;
    logic              flush_i;

    logic              wb_ready_i;
    logic              wb_valid_o;
    logic              wb_we_o;
    logic [PHY_W-1:0]  wb_tag_o;
    logic [DATA_W-1:0] wb_data_o;
    logic              ctrl_valid_o;
    logic [AL_W-1:0]   ctrl_al_id_o;
    logic [FLG_W-1:0]  ctrl_flags_o;

    logic              byp_valid_o;
    logic [PHY_W-1:0]  byp_tag_o;
    logic [DATA_W-1:0] byp_data_o;

    modport slave (
        input  valid_i, result_i, flags_i, has_dest_i, phy_dest_i, al_id_i,
        input  flush_i, wb_ready_i,
        output ready_o,
        output wb_valid_o, wb_we_o, wb_tag_o, wb_data_o,
        output ctrl_valid_o, ctrl_al_id_o, ctrl_flags_o,
        output byp_valid_o, byp_tag_o, byp_data_o
    );

    modport master (
        output valid_i, result_i, flags_i, has_dest_i, phy_dest_i, al_id_i,
        output flush_i, wb_ready_i,
        input  ready_o,
        input  wb_valid_o, wb_we_o, wb_tag_o, wb_data_o,
        input  ctrl_valid_o, ctrl_al_id_o, ctrl_flags_o,
        input  byp_valid_o, byp_tag_o, byp_data_o
    );

endinterface

// File: rtl/alu_wb_skid_buf.sv
// Two-entry in-order skid buffer (head + skid register), 1-cycle latency, registered
// in_rdy_o that drops the cycle after the buffer fills; flush empties it at once.
module alu_wb_skid_buf
    import alu_writeback_stage_pkg::*;
#(
    parameter int ENTRY_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               in_vld_i,
    input  logic [ENTRY_W-1:0] in_dat_i,
    output logic               in_rdy_o,
    input  logic               out_rdy_i,
    output logic               out_vld_o,
    output logic [ENTRY_W-1:0] out_dat_o
);

    occ_state_e         state_q, state_d;
    logic               rdy_q;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic               accept;
    logic               drain;

    assign out_vld_o = (state_q != OCC_EMPTY);
    assign out_dat_o = head_q;
    assign in_rdy_o  = rdy_q;

    assign accept = in_vld_i & rdy_q & ~flush_i;
    assign drain  = out_vld_o & out_rdy_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        // A drain coinciding with flush is consumed downstream; nothing to keep.
        if (flush_i) begin
            state_d = OCC_EMPTY;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (accept) begin
                        head_d  = in_dat_i;
                        state_d = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (accept && drain) begin
                        head_d = in_dat_i;
                    end else if (accept) begin
                        skid_d  = in_dat_i;
                        state_d = OCC_FULL;
                    end else if (drain) begin
                        state_d = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (drain) begin
                        head_d  = skid_q;
                        state_d = OCC_ONE;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OCC_EMPTY;
            rdy_q   <= 1'b1;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d != OCC_FULL);
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 1-cycle latency to PRF write / active-list completion, skid-buffered
// with registered ready_o. Define ALU_WB_BYPASS_EN for a same-cycle combinational bypass.
module alu_writeback_stage
    import alu_writeback_stage_pkg::*;
#(
    parameter int DATA_W = SIZE_DATA,
    parameter int PHY_W  = SIZE_PHYSICAL_LOG,
    parameter int AL_W   = SIZE_ACTIVELIST_LOG,
    parameter int FLG_W  = EXECUTION_FLAGS
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_writeback_stage_if.slave bus
);

    localparam int              ENTRY_W   = DATA_W + FLG_W + 1 + PHY_W + AL_W;
    localparam logic [FLG_W-1:0] EXEC_MASK = FLG_W'(1) << FLAG_EXEC;

    logic [ENTRY_W-1:0] in_dat;
    logic [ENTRY_W-1:0] head_dat;
    logic               head_vld;
    logic               in_rdy;

    logic [DATA_W-1:0]  head_result;
    logic [FLG_W-1:0]   head_flags;
    logic               head_has_dest;
    logic [PHY_W-1:0]   head_tag;
    logic [AL_W-1:0]    head_al_id;

    // Anything leaving this stage has executed, whatever the ALU reported.
    assign in_dat = {bus.result_i, bus.flags_i | EXEC_MASK, bus.has_dest_i,
                     bus.phy_dest_i, bus.al_id_i};

    alu_wb_skid_buf #(
        .ENTRY_W (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush_i   (bus.flush_i),
        .in_vld_i  (bus.valid_i),
        .in_dat_i  (in_dat),
        .in_rdy_o  (in_rdy),
        .out_rdy_i (bus.wb_ready_i),
        .out_vld_o (head_vld),
        .out_dat_o (head_dat)
    );

    assign {head_result, head_flags, head_has_dest, head_tag, head_al_id} = head_dat;

    assign bus.ready_o      = in_rdy;
    assign bus.wb_valid_o   = head_vld;
    assign bus.wb_we_o      = head_vld & head_has_dest;
    assign bus.wb_tag_o     = head_tag;
    assign bus.wb_data_o    = head_result;
    assign bus.ctrl_valid_o = head_vld;
    assign bus.ctrl_al_id_o = head_al_id;
    assign bus.ctrl_flags_o = head_flags;

`ifdef ALU_WB_BYPASS_EN
    // Forward the instruction being accepted this cycle for wakeup/operand bypass.
    assign bus.byp_valid_o = bus.valid_i & bus.has_dest_i & in_rdy & ~bus.flush_i;
    assign bus.byp_tag_o   = bus.phy_dest_i;
    assign bus.byp_data_o  = bus.result_i;
`else
    assign bus.byp_valid_o = head_vld & head_has_dest;
    assign bus.byp_tag_o   = head_tag;
    assign bus.byp_data_o  = head_result;
`endif

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed-vector bench with a scoreboard queue checked by an independent writeback monitor.
module tb_alu_writeback_stage;
    import alu_writeback_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_writeback_stage_if bus ();

    alu_writeback_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    wb_entry_t sb_q[$];
    wb_entry_t mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] res, input logic [5:0] flg, input logic hd,
                         input logic [6:0] tag, input logic [4:0] al);
        bus.valid_i    = 1'b1;
        bus.result_i   = res;
        bus.flags_i    = flg;
        bus.has_dest_i = hd;
        bus.phy_dest_i = tag;
        bus.al_id_i    = al;
        #1;
    endtask

    task automatic expect_wb(input logic [31:0] res, input logic [5:0] flg, input logic hd,
                             input logic [6:0] tag, input logic [4:0] al);
        wb_entry_t e;
        e.result   = res;
        e.flags    = flg;
        e.has_dest = hd;
        e.phy_dest = tag;
        e.al_id    = al;
        sb_q.push_back(e);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wb_valid"},   64'(bus.wb_valid_o),   64'd0);
        chk({tag, "_wb_we"},      64'(bus.wb_we_o),      64'd0);
        chk({tag, "_ctrl_valid"}, 64'(bus.ctrl_valid_o), 64'd0);
        chk({tag, "_wb_tag"},     64'(bus.wb_tag_o),     64'd0);
        chk({tag, "_wb_data"},    64'(bus.wb_data_o),    64'd0);
        chk({tag, "_al_id"},      64'(bus.ctrl_al_id_o), 64'd0);
        chk({tag, "_flags"},      64'(bus.ctrl_flags_o), 64'd0);
        chk({tag, "_byp_valid"},  64'(bus.byp_valid_o),  64'd0);
        chk({tag, "_ready"},      64'(bus.ready_o),      64'd1);
    endtask

    // Monitor: every writeback the consumer takes must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.wb_valid_o && bus.wb_ready_i) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wb: got tag 0x%0h data 0x%0h expected no writeback at %0t",
                         bus.wb_tag_o, bus.wb_data_o, $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("mon_data",       64'(bus.wb_data_o),    64'(mon_e.result));
                chk("mon_tag",        64'(bus.wb_tag_o),     64'(mon_e.phy_dest));
                chk("mon_al_id",      64'(bus.ctrl_al_id_o), 64'(mon_e.al_id));
                chk("mon_flags",      64'(bus.ctrl_flags_o), 64'(mon_e.flags));
                chk("mon_we",         64'(bus.wb_we_o),      64'(mon_e.has_dest));
                chk("mon_ctrl_valid", 64'(bus.ctrl_valid_o), 64'd1);
            end
        end
    end

    typedef struct {
        logic [31:0] res;
        logic [5:0]  flg;
        logic [5:0]  exp_flg;
        logic        hd;
        logic [6:0]  tag;
        logic [4:0]  al;
    } vec_t;

    vec_t tput_vecs[4] = '{
        '{32'h1234_5678, 6'b101001, 6'b101101, 1'b1, 7'd20, 5'd10},
        '{32'h0000_0000, 6'b000100, 6'b000100, 1'b1, 7'd21, 5'd11},
        '{32'hFFFF_FFFF, 6'b111111, 6'b111111, 1'b0, 7'd127, 5'd31},
        '{32'h8000_0001, 6'b010001, 6'b010101, 1'b1, 7'd0,  5'd0}
    };

    initial begin
        reset          = 1'b1;
        bus.valid_i    = 1'b0;
        bus.result_i   = '0;
        bus.flags_i    = '0;
        bus.has_dest_i = 1'b0;
        bus.phy_dest_i = '0;
        bus.al_id_i    = '0;
        bus.flush_i    = 1'b0;
        bus.wb_ready_i = 1'b0;
        step();
        step();
        chk_idle_outputs("reset");
        reset = 1'b0;

        // Single instruction, latency one cycle.
        bus.wb_ready_i = 1'b1;
        drive(32'h0000_0005, 6'b000000, 1'b1, 7'd7, 5'd3);
        expect_wb(32'h0000_0005, 6'b000100, 1'b1, 7'd7, 5'd3);
        step();
        bus.valid_i = 1'b0;
        chk("t1_wb_valid", 64'(bus.wb_valid_o),      64'd1);
        chk("t1_wb_we",    64'(bus.wb_we_o),         64'd1);
        chk("t1_wb_tag",   64'(bus.wb_tag_o),        64'd7);
        chk("t1_wb_data",  64'(bus.wb_data_o),       64'd5);
        chk("t1_exec_bit", 64'(bus.ctrl_flags_o[2]), 64'd1);
        step();
        chk("t1_drained", 64'(bus.wb_valid_o), 64'd0);

        // Back-pressure: A and B held, C refused, then A, B drain in order.
        bus.wb_ready_i = 1'b0;
        drive(32'h0000_00A0, 6'b000000, 1'b1, 7'd10, 5'd1);
        expect_wb(32'h0000_00A0, 6'b000100, 1'b1, 7'd10, 5'd1);
        step();
        chk("t2_ready_after_a", 64'(bus.ready_o), 64'd1);
        drive(32'h0000_00B0, 6'b000000, 1'b1, 7'd11, 5'd2);
        expect_wb(32'h0000_00B0, 6'b000100, 1'b1, 7'd11, 5'd2);
        step();
        chk("t2_ready_after_b", 64'(bus.ready_o), 64'd0);
        drive(32'h0000_00C0, 6'b000000, 1'b1, 7'd12, 5'd4);
        step();
        chk("t2_ready_full", 64'(bus.ready_o),   64'd0);
        chk("t2_head_is_a",  64'(bus.wb_data_o), 64'h00A0);
        bus.valid_i    = 1'b0;
        bus.wb_ready_i = 1'b1;
        step();
        chk("t2_ready_back", 64'(bus.ready_o),   64'd1);
        chk("t2_head_is_b",  64'(bus.wb_data_o), 64'h00B0);
        step();
        chk("t2_drained", 64'(bus.wb_valid_o), 64'd0);

        // Flush while full, with a live input in the same cycle.
        bus.wb_ready_i = 1'b0;
        drive(32'h0000_00D1, 6'b000000, 1'b1, 7'd13, 5'd5);
        step();
        drive(32'h0000_00D2, 6'b000000, 1'b1, 7'd14, 5'd6);
        step();
        chk("t3_full_ready", 64'(bus.ready_o), 64'd0);
        drive(32'h0000_00D3, 6'b000000, 1'b1, 7'd15, 5'd7);
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        chk("t3_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        chk("t3_wb_we",    64'(bus.wb_we_o),    64'd0);
        chk("t3_ready",    64'(bus.ready_o),    64'd1);
        bus.wb_ready_i = 1'b1;
        step();
        step();
        chk("t3_stays_empty", 64'(bus.wb_valid_o), 64'd0);

        // Exception flag, no destination register.
        drive(32'h0000_0011, 6'b000010, 1'b0, 7'd3, 5'd9);
        expect_wb(32'h0000_0011, 6'b000110, 1'b0, 7'd3, 5'd9);
        step();
        bus.valid_i = 1'b0;
        chk("t4_ctrl_valid", 64'(bus.ctrl_valid_o), 64'd1);
        chk("t4_flags",      64'(bus.ctrl_flags_o), 64'b000110);
        chk("t4_wb_we",      64'(bus.wb_we_o),      64'd0);
        step();

        // Back-to-back stream at full throughput.
        foreach (tput_vecs[i]) begin
            drive(tput_vecs[i].res, tput_vecs[i].flg, tput_vecs[i].hd, tput_vecs[i].tag,
                  tput_vecs[i].al);
            expect_wb(tput_vecs[i].res, tput_vecs[i].exp_flg, tput_vecs[i].hd,
                      tput_vecs[i].tag, tput_vecs[i].al);
            chk("t5_ready", 64'(bus.ready_o), 64'd1);
            step();
        end
        bus.valid_i = 1'b0;
        step();
        chk("t5_drained", 64'(bus.wb_valid_o), 64'd0);

        // Bypass timing.
        drive(32'hDEAD_BEEF, 6'b000000, 1'b1, 7'd12, 5'd5);
        expect_wb(32'hDEAD_BEEF, 6'b000100, 1'b1, 7'd12, 5'd5);
`ifdef ALU_WB_BYPASS_EN
        chk("t6_byp_valid_now", 64'(bus.byp_valid_o), 64'd1);
        chk("t6_byp_tag_now",   64'(bus.byp_tag_o),   64'd12);
        chk("t6_byp_data_now",  64'(bus.byp_data_o),  64'hDEAD_BEEF);
        step();
        bus.valid_i = 1'b0;
`else
        chk("t6_byp_valid_now", 64'(bus.byp_valid_o), 64'd0);
        step();
        bus.valid_i = 1'b0;
        chk("t6_byp_valid_next", 64'(bus.byp_valid_o), 64'd1);
        chk("t6_byp_tag_next",   64'(bus.byp_tag_o),   64'd12);
        chk("t6_byp_data_next",  64'(bus.byp_data_o),  64'hDEAD_BEEF);
`endif
        step();

        // Reset beats flush and input while full.
        bus.wb_ready_i = 1'b0;
        drive(32'h0000_00E1, 6'b000001, 1'b1, 7'd30, 5'd12);
        step();
        drive(32'h0000_00E2, 6'b000001, 1'b1, 7'd31, 5'd13);
        step();
        chk("t7_full_ready", 64'(bus.ready_o), 64'd0);
        drive(32'h0000_00E3, 6'b000001, 1'b1, 7'd32, 5'd14);
        reset       = 1'b1;
        bus.flush_i = 1'b1;
        step();
        reset       = 1'b0;
        bus.flush_i = 1'b0;
        bus.valid_i = 1'b0;
        #1;
        chk_idle_outputs("t7");
        bus.wb_ready_i = 1'b1;
        step();
        chk("t7_stays_empty", 64'(bus.wb_valid_o), 64'd0);

        step();
        chk("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
